pipe_skid_stage: RTL
====================

# pipe_skid_stage

Two-entry valid/ready pipeline skid stage that sits directly upstream of the team's enable/set data registers. It converts a streaming valid/ready handshake into per-register load-enable and synchronous-clear control. The stage gives full throughput with registered `s_ready_o`, which breaks the ready combinational path across pipeline boundaries.

## Interface
- `WIDTH`, default 32: data width in bits.
- `RST_DATA`, default 0: value loaded into both data registers on reset and on flush.

- `clk`  in  1: single clock; all logic on rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `flush_i`  in  1: synchronous clear of stage contents (see Configuration).
- `s_valid_i`  in  1: upstream data valid.
- `s_ready_o`  out  1: stage can accept; registered.
- `s_data_i`  in  WIDTH: upstream data.
- `m_valid_o`  out  1: output data valid; registered.
- `m_ready_i`  in  1: downstream accepts.
- `m_data_o`  out  WIDTH: output data; registered.
- `level_o`  out  2: occupancy, 0..2.

## Operation
- Storage: main register (drives `m_data_o`) and skid register. Each is loaded only when written; otherwise it holds.
- Input transfer: `s_valid_i & s_ready_o`. Output transfer: `m_valid_o & m_ready_i`.
- States:
  - EMPTY (level 0)
  - ONE (main valid, level 1)
  - FULL (main and skid valid, level 2)
- `s_ready_o` = 1 in EMPTY and ONE, 0 in FULL. `m_valid_o` = 1 in ONE and FULL.
- Transitions:
  - EMPTY, in: main←`s_data_i`, go to ONE.
  - EMPTY, no in: stay EMPTY.
  - ONE, in and out: main←`s_data_i`, stay ONE.
  - ONE, in only: skid←`s_data_i`, go to FULL.
  - ONE, out only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, out: main←skid, go to ONE. No input is possible because `s_ready_o`=0.
  - FULL, no out: hold.
- Ordering: data leaves in arrival order. No drop, no duplication.
- `m_data_o` is stable while `m_valid_o & ~m_ready_i`.
- Upstream holds `s_data_i` stable while `s_valid_i & ~s_ready_o`. The stage does not check this.
- `m_valid_o` does not depend combinationally on `m_ready_i`.
- Flush (when compiled in): highest priority below reset.
  - Next state is EMPTY; both data registers ←`RST_DATA`.
  - An input transfer in the flush cycle is discarded.
  - An output transfer in the flush cycle counts as completed.
- Reset values: `m_valid_o`=0, `s_ready_o`=1, `m_data_o`=`RST_DATA`, `level_o`=0, skid=`RST_DATA`, state EMPTY.
- Reset mid-operation: contents are lost immediately and asynchronously. Outputs take their reset values while `rstn`=0.

## Timing
- Latency: data accepted at edge N appears on `m_data_o` with `m_valid_o`=1 after edge N, so it is visible in cycle N+1.
- Throughput: one transfer per cycle sustained while `m_ready_i`=1.
- `s_ready_o` deasserts the cycle after the stage enters FULL. It reasserts the cycle after the output transfer from FULL.
- Back-pressure absorption: one extra beat after `m_ready_i` falls.
- Combinational paths:
  - None from `m_ready_i` to `s_ready_o`.
  - None from `s_valid_i` to `m_valid_o`.
  - All outputs come straight from flops.

## Configuration
- Macro `PIPE_SKID_FLUSH_EN`.
- Defined: `flush_i` behaves as in Operation.
- Undefined: `flush_i` is ignored (port retained). No clear logic is generated, and data registers are affected only by reset and handshake loads.

## Test plan
- Reset then idle:
  - During `rstn`=0, `m_valid_o`=0, `s_ready_o`=1, `level_o`=0, `m_data_o`=`RST_DATA`.
  - After release with no stimulus, outputs are unchanged.
- Streaming: `m_ready_i`=1, send 0x11..0x18 on consecutive cycles. Expect identical sequence on `m_data_o`, each one cycle later, with no bubbles and `s_ready_o` constantly 1.
- Back-pressure: send 0xA1, 0xA2, 0xA3 with `m_ready_i`=0.
  - 0xA1 and 0xA2 are accepted; `level_o`=2; `s_ready_o`=0; 0xA3 is held upstream.
  - Raise `m_ready_i`: outputs are 0xA1, 0xA2, 0xA3 in order, none lost.
- Simultaneous in/out in ONE: main=0x55, `s_valid_i` with 0x66 and `m_ready_i`=1 in the same cycle. Next cycle `m_data_o`=0x66, `level_o`=1.
- Flush (macro defined): in FULL (0xB1, 0xB2), assert `flush_i` for one cycle.
  - Next cycle `level_o`=0, `m_valid_o`=0, `s_ready_o`=1, `m_data_o`=`RST_DATA`.
  - An input presented in the flush cycle never appears at the output.
  - With the macro undefined, the same stimulus leaves `level_o`=2 and 0xB1 on `m_data_o`.
- Async reset mid-stream: assert `rstn`=0 between clock edges while in FULL. Outputs go to reset values without a clock edge.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
//
// Two-entry valid/ready skid stage placed in front of enable/set data
// registers. It turns a streaming handshake into load-enables for a main
// register (drives m_data_o) and a skid register. s_ready_o is registered, so
// there is no combinational path from m_ready_i back upstream. The stage still
// sustains one transfer per cycle.
//
// Parameters
//   WIDTH     data width in bits
//   RST_DATA  value held by both data registers after reset (and after flush)
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   flush_i    synchronous clear of the stage contents (optional feature)
//   s_valid_i  upstream valid
//   s_ready_o  stage can accept (registered)
//   s_data_i   upstream data
//   m_valid_o  output valid (registered)
//   m_ready_i  downstream accepts
//   m_data_o   output data (registered)
//   level_o    occupancy 0..2 (registered)
//
// Configuration
//   PIPE_SKID_FLUSH_EN  when defined, flush_i clears the stage. It has priority
//                       over handshakes. When undefined, flush_i is ignored and
//                       no clear logic is built.
// ---------------------------------------------------------------------------
module pipe_skid_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       level_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_s_ready;
    logic             r_m_valid;
    logic [1:0]       r_level;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;
    logic             w_s_ready_nxt;
    logic             w_m_valid_nxt;
    logic [1:0]       w_level_nxt;

`ifdef PIPE_SKID_FLUSH_EN
    logic             w_flush;
    assign w_flush = flush_i;
`else
    // The port is kept for a uniform footprint. Without the feature it has no load.
    logic             w_unused_flush;
    assign w_unused_flush = flush_i;
`endif

    // Handshakes use the registered flags. This keeps m_ready_i away from s_ready_o.
    assign w_in_xfer  = s_valid_i & r_s_ready;
    assign w_out_xfer = r_m_valid & m_ready_i;

    // -----------------------------------------------------------------------
    // Next-state and load-enable decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;

        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_load_main = 1'b1;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // s_ready_o is low here, so only the output side can move.
                if (w_out_xfer) begin
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

`ifdef PIPE_SKID_FLUSH_EN
        // Any transfer in this cycle is dropped. The clear itself is in the
        // data-register process.
        if (w_flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main      = 1'b0;
            w_main_from_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Output decode: the next values of the registered status outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_s_ready_nxt = 1'b1;
        w_m_valid_nxt = 1'b0;
        w_level_nxt   = 2'd0;
        unique case (w_state_nxt)
            ST_EMPTY: begin
                w_s_ready_nxt = 1'b1;
                w_m_valid_nxt = 1'b0;
                w_level_nxt   = 2'd0;
            end
            ST_ONE: begin
                w_s_ready_nxt = 1'b1;
                w_m_valid_nxt = 1'b1;
                w_level_nxt   = 2'd1;
            end
            ST_FULL: begin
                w_s_ready_nxt = 1'b0;
                w_m_valid_nxt = 1'b1;
                w_level_nxt   = 2'd2;
            end
            default: begin
                w_s_ready_nxt = 1'b1;
                w_m_valid_nxt = 1'b0;
                w_level_nxt   = 2'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge.
        if (!rstn) begin
            r_state   <= ST_EMPTY;
            r_s_ready <= 1'b1;
            r_m_valid <= 1'b0;
            r_level   <= 2'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= w_s_ready_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_level   <= w_level_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Data registers: load only when written, otherwise hold
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: the data registers are reset on purpose because m_data_o must
        // show RST_DATA. This is two registers, not an array, so the reset is cheap.
        if (!rstn) begin
            r_main <= RST_DATA;
            r_skid <= RST_DATA;
        end else begin
`ifdef PIPE_SKID_FLUSH_EN
            if (w_flush) begin
                r_main <= RST_DATA;
                r_skid <= RST_DATA;
            end else begin
                if (w_load_main) r_main <= w_main_from_skid ? r_skid : s_data_i;
                if (w_load_skid) r_skid <= s_data_i;
            end
`else
            if (w_load_main) r_main <= w_main_from_skid ? r_skid : s_data_i;
            if (w_load_skid) r_skid <= s_data_i;
`endif
        end
    end

    assign s_ready_o = r_s_ready;
    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_main;
    assign level_o   = r_level;

endmodule
